// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: command sequencer between the host stream fabric and the
// tiny_dnn accelerator host port.
//
// Accepts LOAD (stream weights into every core) and RUN (clear accumulators,
// stream one input vector, read back one fp32 dot product per core) commands
// and turns them into the cycle-exact write/init/exec/a/d port protocol.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_len                 0 = LOAD, 1 = RUN; vector length N per core
//   in_valid/in_ready, in_data      fp32 weight or input words
//   res_valid/res_ready             result handshake
//   res_data, res_idx, res_last     result word, core index, last-core flag
//   busy, done                      not idle; one-cycle completion pulse
//   dnn_write/init/exec, dnn_a/d    registered drive to the accelerator
//   dnn_x                           accelerator result (registered on its side)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready=1
// S_LOAD  | accepting weights core-major, one dnn_write per word
// S_INIT  | issue one dnn_init to clear the accumulators
// S_EXEC  | accepting input words, one dnn_exec per word
// S_DRAIN | no controls, lets the last multiply-accumulate complete
// S_RD_A  | dnn_a = k on the port so the accelerator registers x[k]
// S_RD_W  | present x[k] on the result stream until accepted
// S_DONE  | one-cycle done pulse
module tiny_dnn_seq #(
  parameter int F_NUM  = 16,
  parameter int F_SIZE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [9:0]  cmd_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_idx,
  output logic        res_last,
  output logic        busy,
  output logic        done,
  output logic        dnn_write,
  output logic        dnn_init,
  output logic        dnn_exec,
  output logic [12:0] dnn_a,
  output logic [31:0] dnn_d,
  input  logic [31:0] dnn_x
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_EXEC, S_DRAIN, S_RD_A, S_RD_W, S_DONE
  } state_t;

  localparam logic [9:0] MAX_LEN   = 10'(F_SIZE);
  localparam logic [3:0] LAST_CORE = 4'(F_NUM - 1);

  state_t      state_q, state_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  idx_q, idx_d;
  logic [3:0]  c_q, c_d;
  logic [3:0]  k_q, k_d;
  logic        dnn_write_q, dnn_write_d;
  logic        dnn_init_q, dnn_init_d;
  logic        dnn_exec_q, dnn_exec_d;
  logic [12:0] dnn_a_q, dnn_a_d;
  logic [31:0] dnn_d_q, dnn_d_d;
  logic [9:0]  len_sat;

  assign len_sat = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      c_q         <= '0;
      k_q         <= '0;
      dnn_write_q <= 1'b0;
      dnn_init_q  <= 1'b0;
      dnn_exec_q  <= 1'b0;
      dnn_a_q     <= '0;
      dnn_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      k_q         <= k_d;
      dnn_write_q <= dnn_write_d;
      dnn_init_q  <= dnn_init_d;
      dnn_exec_q  <= dnn_exec_d;
      dnn_a_q     <= dnn_a_d;
      dnn_d_q     <= dnn_d_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    c_d         = c_q;
    k_d         = k_q;
    dnn_write_d = 1'b0;
    dnn_init_d  = 1'b0;
    dnn_exec_d  = 1'b0;
    dnn_a_d     = '0;
    dnn_d_d     = '0;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    res_last    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d = len_sat;
          idx_d = '0;
          c_d   = '0;
          k_d   = '0;
          if (cmd_op)              state_d = S_INIT;
          else if (len_sat == '0)  state_d = S_DONE;
          else                     state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dnn_write_d = 1'b1;
          dnn_a_d     = {c_q, idx_q[8:0]};
          dnn_d_d     = in_data;
          if (idx_q == len_q - 10'd1) begin
            idx_d = '0;
            c_d   = c_q + 4'd1;
            if (c_q == LAST_CORE) state_d = S_DONE;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end

      S_INIT: begin
        dnn_init_d = 1'b1;
        state_d    = (len_q == '0) ? S_DRAIN : S_EXEC;
      end

      S_EXEC: begin
        in_ready = (idx_q < len_q);
        if (in_ready && in_valid) begin
          dnn_exec_d = 1'b1;
          dnn_a_d    = {4'b0, idx_q[8:0]};
          dnn_d_d    = in_data;
          idx_d      = idx_q + 10'd1;
          if (idx_q == len_q - 10'd1) state_d = S_DRAIN;
        end
      end

      // The read address is set up one state early so that it is on the port
      // during RD_A and the accelerator's registered x is valid in RD_W.
      S_DRAIN: begin
        dnn_a_d = {9'b0, k_q};
        state_d = S_RD_A;
      end

      S_RD_A: begin
        dnn_a_d = {9'b0, k_q};
        state_d = S_RD_W;
      end

      S_RD_W: begin
        res_valid = 1'b1;
        res_last  = (k_q == LAST_CORE);
        dnn_a_d   = {9'b0, k_q};
        if (res_ready) begin
          if (k_q == LAST_CORE) begin
            dnn_a_d = '0;
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            dnn_a_d = {9'b0, k_q + 4'd1};
            state_d = S_RD_A;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign res_idx   = k_q;
  assign res_data  = res_valid ? dnn_x : 32'd0;
  assign dnn_write = dnn_write_q;
  assign dnn_init  = dnn_init_q;
  assign dnn_exec  = dnn_exec_q;
  assign dnn_a     = dnn_a_q;
  assign dnn_d     = dnn_d_q;

endmodule

// File: doc/tiny_dnn_seq.md
# tiny_dnn_seq

Command sequencer that drives the accelerator's `write`/`init`/`exec`/`a`/`d` host port and collects its 16 `x` results. It accepts LOAD (stream weights into all 16 cores) and RUN (clear accumulators, stream an input vector, read back 16 fp32 dot products) commands over valid/ready, and converts them into the cycle-exact port protocol. It sits between the host DMA/stream fabric and `tiny_dnn_top`.

## Interface
- `F_NUM`, 16: number of cores; sets the result count and the core-select field `a[12:9]`.
- `F_SIZE`, 512: maximum vector length per core; sets the index field `a[8:0]`.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 1: 0 = LOAD, 1 = RUN.
- `cmd_len` in 10: vector length N per core.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32: fp32 weight or input words.
- `res_valid` out 1, `res_ready` in 1, `res_data` out 32, `res_idx` out 4, `res_last` out 1: result stream.
- `busy` out 1, `done` out 1: status; `done` is a one-cycle pulse at command completion.
- `dnn_write`, `dnn_init`, `dnn_exec` out 1, `dnn_a` out 13, `dnn_d` out 32: registered drive to the accelerator.
- `dnn_x` in 32: accelerator result, registered inside the accelerator.

## Operation
- States: IDLE, LOAD, INIT, EXEC, DRAIN, RD_A, RD_W, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch op and N. N=0 stays 0; N>512 saturates to 512.
  - Clear index counter `idx` and core counter `c`.
  - LOAD goes to LOAD; RUN goes to INIT.
- LOAD:
  - `in_ready`=1.
  - Each accepted word drives the next cycle with `dnn_write`=1, `dnn_a`={c[3:0], idx[8:0]}, `dnn_d`=in_data.
  - Word order is core-major: idx 0..N-1 for core 0, then core 1, and so on.
  - After 16·N words go to DONE. N=0 goes straight to DONE.
- INIT: drive `dnn_init`=1 for exactly one cycle, then go to EXEC.
- EXEC:
  - `in_ready`=1 while idx<N.
  - Each accepted word drives the next cycle with `dnn_exec`=1, `dnn_a`={4'b0, idx}, `dnn_d`=in_data.
  - A cycle with no handshake drives `dnn_exec`=0 (bubble; accumulators hold).
  - After the Nth word go to DRAIN. N=0 goes directly to DRAIN.
- DRAIN: one cycle with all `dnn_*` controls 0, so the last multiply-accumulate lands.
- RD_A: drive `dnn_a`=k with all controls 0 for one cycle, then go to RD_W.
- RD_W:
  - Keep `dnn_a`=k.
  - `res_valid`=1, `res_data`=`dnn_x`, `res_idx`=k, `res_last`=(k==15).
  - On handshake: k++, go to RD_A; if k==15, go to DONE instead.
  - Without handshake, stay; `dnn_x` is stable.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = state≠IDLE.
- `dnn_write`, `dnn_init` and `dnn_exec` are mutually exclusive in every cycle.
- `in_ready` is 0 in all states other than LOAD and EXEC.
- `cmd_ready` is 0 whenever not IDLE; a command presented while busy is held, not dropped.

## Timing
- Reset (`rst_n`=0 at a clk edge) forces, from the next cycle:
  - state = IDLE;
  - `dnn_*`, `res_valid`, `res_last`, `done` and counters = 0;
  - `busy` = 0.
- Reset mid-command aborts it. Accumulator contents are undefined until the next INIT.
- `dnn_*` outputs are registered: a word accepted at edge t appears on `dnn_*` from t to t+1.
- RUN latency with no input gaps and `res_ready`=1: cmd handshake → INIT (1) → N EXEC → DRAIN (1) → 16×(RD_A+RD_W) (32) → DONE (1). First `res_valid` appears N+3 cycles after INIT.
- LOAD with no gaps: 16·N+1 cycles from command handshake to `done`.
- `res_data` is valid only while `res_valid`=1 and must not change while stalled.

## Test plan
- Reset values: hold `rst_n`=0 for 3 cycles during EXEC → all `dnn_*` = 0, `busy`=0, `cmd_ready`=1; no `done` pulse.
- LOAD and RUN, all ones:
  - LOAD N=4 with every weight 0x3F800000 → exactly 64 `dnn_write` pulses, `dnn_a` = 0x000..0x003, 0x200.., …, 0x1E03.
  - RUN N=4 with inputs 0x40000000 → 16 results, all 0x41000000 (8.0); `res_last` only on idx 15.
- Per-core weights: core c weights = float(c), N=4, inputs 2.0 → `res_data`[c] = 8c. Core 0 gives 0x00000000; core 1 gives 0x41000000.
- Gaps and back-pressure, RUN N=3:
  - Toggle `in_valid` every other cycle → `dnn_exec` pulses match the handshakes exactly; results are unchanged.
  - Hold `res_ready`=0 for 5 cycles at k=7 → `res_data` and `res_idx` stay stable.
- Length edges:
  - LOAD N=0 → `done` one cycle after the handshake, no writes.
  - RUN N=0 → one init pulse, 16 zero results.
  - `cmd_len`=600 → 512 exec pulses.
- Command while busy: `cmd_valid` held high during RUN → accepted only in IDLE after `done`; no `dnn_*` pulse overlaps the earlier command.
